// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared FSM state and owner encodings for the two-master bus arbiter
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OWN_CPU,
        ST_OWN_DMA,
        ST_ABORT
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DMA  = 2'b10;

endpackage

// File: rtl/wb_arb_timer.sv
// rtl/wb_arb_timer.sv - wait-state counter that flags a strobe left unanswered for TIMEOUT cycles
module wb_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] count_q;

    // Expire on the wait cycle that brings the count to TIMEOUT; an ack/err suppresses inc, so it wins.
    assign expire = inc && (count_q == W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + W'(1);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - CPU/DMA arbiter onto one shared bus with registered grant and wait timeout
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int TIMEOUT  = 255,
    parameter int DMA_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cyc,
    input  logic        cpu_stb,
    input  logic        cpu_we,
    input  logic [31:0] cpu_adr,
    input  logic [31:0] cpu_wdata,
    input  logic [3:0]  cpu_sel,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_err,
    output logic        cpu_stall,
    input  logic        dma_cyc,
    input  logic        dma_stb,
    input  logic        dma_we,
    input  logic [31:0] dma_adr,
    input  logic [31:0] dma_wdata,
    input  logic [3:0]  dma_sel,
    output logic [31:0] dma_rdata,
    output logic        dma_ack,
    output logic        dma_err,
    output logic        dma_stall,
    output logic        bus_cyc,
    output logic        bus_stb,
    output logic        bus_we,
    output logic [31:0] bus_adr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_sel,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic        bus_stall,
    output logic [1:0]  grant,
    output logic        timeout_irq
);

    arb_state_t state_q, state_d;
    logic [1:0] last_owner_q;
    logic       irq_q;
    logic       owned;
    logic       expire;
    logic       timer_clear;
    logic       timer_inc;

    assign owned       = (state_q == ST_OWN_CPU) || (state_q == ST_OWN_DMA);
    assign timer_inc   = bus_stb && !bus_ack && !bus_err;
    assign timer_clear = !owned || bus_ack || bus_err;
    assign timeout_irq = irq_q;

    wb_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_cyc && dma_cyc) begin
                    state_d = ((DMA_PRIO != 0) || (last_owner_q == OWN_CPU)) ? ST_OWN_DMA : ST_OWN_CPU;
                end else if (cpu_cyc) begin
                    state_d = ST_OWN_CPU;
                end else if (dma_cyc) begin
                    state_d = ST_OWN_DMA;
                end
            end
            ST_OWN_CPU: begin
                if (!cpu_cyc)    state_d = ST_IDLE;
                else if (expire) state_d = ST_ABORT;
            end
            ST_OWN_DMA: begin
                if (!dma_cyc)    state_d = ST_IDLE;
                else if (expire) state_d = ST_ABORT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_owner_q <= OWN_DMA;
            irq_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            irq_q   <= (state_d == ST_ABORT);
            if (state_q == ST_IDLE && state_d != ST_IDLE) begin
                last_owner_q <= (state_d == ST_OWN_CPU) ? OWN_CPU : OWN_DMA;
            end
        end
    end

    // During ABORT the aborted owner is still last_owner, which also steers the error.
    always_comb begin
        case (state_q)
            ST_OWN_CPU: grant = OWN_CPU;
            ST_OWN_DMA: grant = OWN_DMA;
            ST_ABORT:   grant = last_owner_q;
            default:    grant = OWN_NONE;
        endcase
    end

    always_comb begin
        bus_cyc   = 1'b0;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_adr   = '0;
        bus_wdata = '0;
        bus_sel   = '0;
        cpu_rdata = '0;
        cpu_ack   = 1'b0;
        cpu_err   = 1'b0;
        cpu_stall = 1'b1;
        dma_rdata = '0;
        dma_ack   = 1'b0;
        dma_err   = 1'b0;
        dma_stall = 1'b1;
        case (state_q)
            ST_OWN_CPU: begin
                bus_cyc   = cpu_cyc;
                bus_stb   = cpu_stb;
                bus_we    = cpu_we;
                bus_adr   = cpu_adr;
                bus_wdata = cpu_wdata;
                bus_sel   = cpu_sel;
                cpu_rdata = bus_rdata;
                cpu_ack   = bus_ack;
                cpu_err   = bus_err;
                cpu_stall = bus_stall;
            end
            ST_OWN_DMA: begin
                bus_cyc   = dma_cyc;
                bus_stb   = dma_stb;
                bus_we    = dma_we;
                bus_adr   = dma_adr;
                bus_wdata = dma_wdata;
                bus_sel   = dma_sel;
                dma_rdata = bus_rdata;
                dma_ack   = bus_ack;
                dma_err   = bus_err;
                dma_stall = bus_stall;
            end
            ST_ABORT: begin
                cpu_err = (last_owner_q == OWN_CPU);
                dma_err = (last_owner_q == OWN_DMA);
            end
            default: ;
        endcase
    end

endmodule
